// File: rtl/hex_digit_formatter_pkg.sv
// rtl/hex_digit_formatter_pkg.sv - shared constants and state encoding for hex_digit_formatter
package hex_digit_formatter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CONV   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  localparam int          HEXFMT_DIGITS     = 6;
  localparam int          HEXFMT_WIDTH      = 20;
  localparam int          HEXFMT_MAX_DEC    = 999999;
  localparam logic [3:0]  HEXFMT_OVF_NIBBLE = 4'hE;

endpackage

// File: rtl/hex_digit_formatter_bcd_add3.sv
// rtl/hex_digit_formatter_bcd_add3.sv - double-dabble correction cell: nibble >= 5 gets +3
//   nibble   : BCD digit before the shift
//   adjusted : digit corrected so the following left shift carries correctly
module bcd_add3 (
  input  logic [3:0] nibble,
  output logic [3:0] adjusted
);

  assign adjusted = (nibble >= 4'd5) ? nibble + 4'd3 : nibble;

endmodule

// File: rtl/hex_digit_formatter.sv
// rtl/hex_digit_formatter.sv - binary to six display digits, decimal (double-dabble) or hex
//   clk, reset_n          : clock, synchronous active-low reset
//   in_valid / in_ready   : request handshake, ready only in IDLE
//   in_value, in_hex,
//   in_blank_en           : request payload, captured on the accept edge
//   digits_out            : digit i on [4i+3:4i], registered at commit
//   blank_out             : leading-zero blank mask, registered at commit
//   overflow              : last decimal value was above 999999
//   out_valid             : one-cycle pulse after each commit
module hex_digit_formatter
  import hex_digit_formatter_pkg::*;
#(
  parameter int DIGITS = HEXFMT_DIGITS,
  parameter int WIDTH  = HEXFMT_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_value,
  input  logic                  in_hex,
  input  logic                  in_blank_en,
  output logic [4*DIGITS-1:0]   digits_out,
  output logic [DIGITS-1:0]     blank_out,
  output logic                  overflow,
  output logic                  out_valid
);

  localparam int                BCD_W     = 4 * DIGITS;
  localparam int                ITER_W    = $clog2(WIDTH);
  localparam logic [WIDTH-1:0]  MAX_DEC   = WIDTH'(HEXFMT_MAX_DEC);
  localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(WIDTH - 1);

  state_t                   state;
  state_t                   state_next;
  logic [ITER_W-1:0]        iter;
  logic [WIDTH-1:0]         bin_q;
  logic [BCD_W-1:0]         bcd_q;
  logic [BCD_W-1:0]         bcd_adj;
  logic [BCD_W+WIDTH-1:0]   shifted;
  logic [BCD_W-1:0]         pre_digits;
  logic [DIGITS-1:0]        pre_blank;
  logic                     upper_zero;
  logic                     hex_q;
  logic                     blank_en_q;
  logic                     ovf_q;
  logic                     accept;
  logic                     in_range;

  assign accept   = in_valid && in_ready;
  assign in_range = (in_value <= MAX_DEC);

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .nibble   (bcd_q[4*g +: 4]),
      .adjusted (bcd_adj[4*g +: 4])
    );
  end

  // One double-dabble step: corrected BCD and remaining binary shift left as one register.
  assign shifted = {bcd_adj[BCD_W-2:0], bin_q, 1'b0};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_next = (in_hex || !in_range) ? ST_COMMIT : ST_CONV;
        end
      end
      ST_CONV: begin
        if (iter == LAST_ITER) begin
          state_next = ST_COMMIT;
        end
      end
      ST_COMMIT: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == ST_IDLE);
  end

  // Digits that the next commit will publish.
  always_comb begin
    pre_digits = bcd_q;
    if (ovf_q) begin
      pre_digits = {DIGITS{HEXFMT_OVF_NIBBLE}};
    end else if (hex_q) begin
      pre_digits = BCD_W'(bin_q);
    end
  end

  // Walk down from the top digit; a digit blanks while every digit above it is zero too.
  // Digit 0 always stays lit so a zero value still shows "0".
  always_comb begin
    pre_blank  = '0;
    upper_zero = blank_en_q;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      upper_zero   = upper_zero && (pre_digits[4*i +: 4] == 4'd0);
      pre_blank[i] = upper_zero;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      iter       <= '0;
      bin_q      <= '0;
      bcd_q      <= '0;
      hex_q      <= 1'b0;
      blank_en_q <= 1'b0;
      ovf_q      <= 1'b0;
      digits_out <= '0;
      blank_out  <= '0;
      overflow   <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            bin_q      <= in_value;
            bcd_q      <= '0;
            iter       <= '0;
            hex_q      <= in_hex;
            blank_en_q <= in_blank_en;
            ovf_q      <= !in_hex && !in_range;
          end
        end
        ST_CONV: begin
          bcd_q <= shifted[BCD_W+WIDTH-1:WIDTH];
          bin_q <= shifted[WIDTH-1:0];
          iter  <= (iter == LAST_ITER) ? '0 : iter + 1'b1;
        end
        ST_COMMIT: begin
          digits_out <= pre_digits;
          blank_out  <= pre_blank;
          overflow   <= ovf_q;
          out_valid  <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hex_digit_formatter.sv
// tb/tb_hex_digit_formatter.sv - self-checking bench for hex_digit_formatter
module tb_hex_digit_formatter;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [19:0] in_value;
  logic        in_hex;
  logic        in_blank_en;
  logic [23:0] digits_out;
  logic [5:0]  blank_out;
  logic        overflow;
  logic        out_valid;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  hex_digit_formatter dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_value    (in_value),
    .in_hex      (in_hex),
    .in_blank_en (in_blank_en),
    .digits_out  (digits_out),
    .blank_out   (blank_out),
    .overflow    (overflow),
    .out_valid   (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: decimal digits by repeated division, hex by nibble extraction,
  // blanking from the position of the most significant nonzero digit.
  task automatic model(input logic [19:0] v, input logic hx, input logic be,
                       output logic [23:0] d, output logic [5:0] b, output logic o);
    int r;
    int msd;
    d = '0;
    o = 1'b0;
    if (hx) begin
      for (int i = 0; i < 5; i++) d[4*i +: 4] = v[4*i +: 4];
    end else if (int'(v) > 999999) begin
      o = 1'b1;
      d = 24'hEEEEEE;
    end else begin
      r = int'(v);
      for (int i = 0; i < 6; i++) begin
        d[4*i +: 4] = 4'(r % 10);
        r = r / 10;
      end
    end
    msd = 0;
    for (int i = 0; i < 6; i++) if (d[4*i +: 4] != 4'd0) msd = i;
    b = '0;
    if (be && !o) for (int i = 0; i < 6; i++) b[i] = (i > msd);
  endtask

  task automatic run_conv(input logic [19:0] v, input logic hx, input logic be, input string tag);
    logic [23:0] ed;
    logic [5:0]  eb;
    logic        eo;
    int          lat;
    int          n;
    bit          ready_low;
    model(v, hx, be, ed, eb, eo);
    lat = (hx || int'(v) > 999999) ? 1 : 21;
    check({tag, "_ready_pre"}, 32'(in_ready), 32'd1);
    in_valid    = 1'b1;
    in_value    = v;
    in_hex      = hx;
    in_blank_en = be;
    tick;
    in_valid    = 1'b0;
    in_value    = 20'($urandom);
    in_hex      = 1'($urandom);
    in_blank_en = 1'($urandom);
    n = 0;
    ready_low = 1'b1;
    while (n < 40) begin
      if (in_ready !== 1'b0) ready_low = 1'b0;
      tick;
      n++;
      if (out_valid === 1'b1) break;
    end
    check({tag, "_latency"},   32'(n), 32'(lat));
    check({tag, "_busy"},      32'(ready_low), 32'd1);
    check({tag, "_digits"},    32'(digits_out), 32'(ed));
    check({tag, "_blank"},     32'(blank_out), 32'(eb));
    check({tag, "_overflow"},  32'(overflow), 32'(eo));
    check({tag, "_ready_post"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int          n;
    int          pulses;
    bit          ready_low;
    logic [19:0] rv;
    logic        rh;
    logic        rb;

    reset_n     = 1'b0;
    in_valid    = 1'b1;
    in_value    = 20'd77;
    in_hex      = 1'b1;
    in_blank_en = 1'b1;
    tick;
    tick;
    reset_n  = 1'b1;
    in_valid = 1'b0;
    check("rst_digits",    32'(digits_out), 32'h0);
    check("rst_blank",     32'(blank_out), 32'h0);
    check("rst_overflow",  32'(overflow), 32'h0);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_ready",     32'(in_ready), 32'h1);
    tick;
    check("rst_no_commit", 32'(out_valid), 32'h0);

    run_conv(20'd123456, 1'b0, 1'b1, "dec123456");
    tick;
    check("dec123456_pulse_width", 32'(out_valid), 32'h0);

    run_conv(20'd42, 1'b0, 1'b1, "dec42");
    run_conv(20'd0,  1'b0, 1'b1, "dec0");
    check("dec0_blank_const", 32'(blank_out), 32'b111110);

    run_conv(20'hABCDE, 1'b1, 1'b1, "hexABCDE");
    check("hexABCDE_const", 32'(digits_out), 32'h0ABCDE);
    run_conv(20'h00001, 1'b1, 1'b1, "hex1_b2b");

    run_conv(20'hF4240, 1'b0, 1'b1, "ovf1000000");
    run_conv(20'd7,     1'b0, 1'b0, "dec7_after_ovf");

    // Request arriving during CONV is held off and must not disturb the running conversion.
    in_valid    = 1'b1;
    in_value    = 20'd123456;
    in_hex      = 1'b0;
    in_blank_en = 1'b1;
    tick;
    in_value  = 20'd999999;
    ready_low = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (in_ready !== 1'b0) ready_low = 1'b0;
      tick;
    end
    in_valid = 1'b0;
    n = 10;
    while (n < 40 && out_valid !== 1'b1) begin
      tick;
      n++;
    end
    check("ignore_busy",    32'(ready_low), 32'd1);
    check("ignore_latency", 32'(n), 32'd21);
    check("ignore_digits",  32'(digits_out), 32'h123456);
    check("ignore_blank",   32'(blank_out), 32'h0);

    // Reset landing on the CONV edge with iter=10.
    tick;
    in_valid    = 1'b1;
    in_value    = 20'd654321;
    in_hex      = 1'b0;
    in_blank_en = 1'b1;
    tick;
    in_valid = 1'b0;
    for (int k = 0; k < 10; k++) tick;
    reset_n = 1'b0;
    tick;
    reset_n = 1'b1;
    check("midrst_digits",    32'(digits_out), 32'h0);
    check("midrst_blank",     32'(blank_out), 32'h0);
    check("midrst_overflow",  32'(overflow), 32'h0);
    check("midrst_out_valid", 32'(out_valid), 32'h0);
    check("midrst_ready",     32'(in_ready), 32'h1);
    pulses = 0;
    for (int k = 0; k < 30; k++) begin
      tick;
      if (out_valid === 1'b1) pulses++;
    end
    check("midrst_no_commit", 32'(pulses), 32'd0);
    check("midrst_digits_hold", 32'(digits_out), 32'h0);

    for (int k = 0; k < 12; k++) begin
      case ($urandom_range(0, 2))
        0:       rv = 20'($urandom);
        1:       rv = 20'($urandom_range(0, 999));
        default: rv = 20'($urandom_range(999990, 1000010));
      endcase
      rh = 1'($urandom);
      rb = 1'($urandom);
      run_conv(rv, rh, rb, $sformatf("rand%0d_v%0d_h%0d_b%0d", k, rv, rh, rb));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
